// File: rtl/cordic_sincos_seq_if.sv
// cordic_sincos_seq_if: angle request, sin/cos result and cordic core operand bus of cordic_sincos_seq
//   slave  : sequencer view (takes angles, drives the core, returns sin/cos)
//   master : environment view (issues angles, models/is the core, consumes results)
interface cordic_sincos_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] angle_in;
    logic             cordic_enable;
    logic             cordic_mode_op;
    logic [1:0]       cordic_mode_coord;
    logic [WIDTH-1:0] cordic_x_in;
    logic [WIDTH-1:0] cordic_y_in;
    logic [WIDTH-1:0] cordic_z_in;
    logic [WIDTH-1:0] cordic_x_out;
    logic [WIDTH-1:0] cordic_y_out;
    logic             cordic_valid;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sin_out;
    logic [WIDTH-1:0] cos_out;
    logic             err;
    modport slave (
        input  in_valid, angle_in, cordic_x_out, cordic_y_out, cordic_valid, out_ready,
        output in_ready, cordic_enable, cordic_mode_op, cordic_mode_coord,
               cordic_x_in, cordic_y_in, cordic_z_in, out_valid, sin_out, cos_out, err
    );
    modport master (
        output in_valid, angle_in, cordic_x_out, cordic_y_out, cordic_valid, out_ready,
        input  in_ready, cordic_enable, cordic_mode_op, cordic_mode_coord,
               cordic_x_in, cordic_y_in, cordic_z_in, out_valid, sin_out, cos_out, err
    );
endinterface

// File: rtl/cordic_sincos_seq.sv
// cordic_sincos_seq: range-reduces a Q16.16 angle, runs a circular/rotation cordic core, returns sin/cos
//   clk, rst (sync, active low) ; bus (slave): in_valid/in_ready/angle_in request,
//   cordic_* core launch/operands/results, out_valid/out_ready/sin_out/cos_out/err result.
//   Define CORDIC_SEQ_WATCHDOG_EN to abort a WAIT after TIMEOUT cycles with err=1.
module cordic_sincos_seq #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    cordic_sincos_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REDUCE = 3'd1;
    localparam logic [2:0] S_FOLD   = 3'd2;
    localparam logic [2:0] S_LAUNCH = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;
    localparam logic [32:0]             TWO_PI   = 33'd411775;
    localparam logic signed [WIDTH-1:0] TWO_PI_S = 411775;
    localparam logic signed [WIDTH-1:0] PI       = 205887;
    localparam logic signed [WIDTH-1:0] HALF_PI  = 102944;
    localparam logic signed [WIDTH-1:0] K_GAIN   = 39797;

    if (WIDTH != 32 || TIMEOUT < 1) begin : g_bad_cfg
        $error("cordic_sincos_seq supports only WIDTH=32 and TIMEOUT>=1");
    end

    logic [2:0]              state_q, state_d;
    logic                    neg_q, neg_d, flip_q, flip_d, err_q, err_d, vprev_q;
    logic [3:0]              k_q, k_d;
    logic [32:0]             a_q, a_d, step;
    logic signed [WIDTH-1:0] z_q, z_d, sin_q, sin_d, cos_q, cos_d, s_unw, s_wrap;
    logic                    edge_v, tmo;

    // Negation that maps the most negative value to the most positive one.
    function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] v);
        return (v == {1'b1, {(WIDTH-1){1'b0}}}) ? ~v : -v;
    endfunction

`ifdef CORDIC_SEQ_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
    assign tmo   = (cnt_q == CW'(TIMEOUT - 1));
    always_ff @(posedge clk) cnt_q <= rst ? cnt_d : '0;
`else
    assign tmo = 1'b0;
`endif

    // Only a fresh rising edge counts, so a level held over from a previous job is ignored.
    assign edge_v = bus.cordic_valid & ~vprev_q;

    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        a_d     = a_q;
        k_d     = k_q;
        z_d     = z_q;
        flip_d  = flip_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        err_d   = err_q;
        step    = TWO_PI << k_q;
        // Negative angles mirror the reduced magnitude, then wrap into (-pi, pi].
        s_unw   = (neg_q && a_q != '0) ? TWO_PI_S - $signed(a_q[WIDTH-1:0]) : $signed(a_q[WIDTH-1:0]);
        s_wrap  = (s_unw > PI) ? s_unw - TWO_PI_S : s_unw;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                state_d = S_REDUCE;
                neg_d   = bus.angle_in[WIDTH-1];
                a_d     = {1'b0, bus.angle_in[WIDTH-1] ? neg_sat($signed(bus.angle_in)) : bus.angle_in};
                k_d     = 4'd13;
                err_d   = 1'b0;
            end
            S_REDUCE: begin
                a_d     = (a_q >= step) ? a_q - step : a_q;
                k_d     = k_q - 4'd1;
                state_d = (k_q == 4'd0) ? S_FOLD : S_REDUCE;
            end
            S_FOLD: begin
                state_d = S_LAUNCH;
                flip_d  = (s_wrap > HALF_PI) || (s_wrap < -HALF_PI);
                z_d     = (s_wrap > HALF_PI) ? s_wrap - PI : (s_wrap < -HALF_PI) ? s_wrap + PI : s_wrap;
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: if (edge_v) begin
                state_d = S_OUT;
                sin_d   = flip_q ? neg_sat($signed(bus.cordic_y_out)) : $signed(bus.cordic_y_out);
                cos_d   = flip_q ? neg_sat($signed(bus.cordic_x_out)) : $signed(bus.cordic_x_out);
            end else if (tmo) begin
                state_d = S_OUT;
                sin_d   = '0;
                cos_d   = '0;
                err_d   = 1'b1;
            end
            S_OUT: state_d = bus.out_ready ? S_IDLE : S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            neg_q   <= 1'b0;
            a_q     <= '0;
            k_q     <= '0;
            z_q     <= '0;
            flip_q  <= 1'b0;
            sin_q   <= '0;
            cos_q   <= '0;
            err_q   <= 1'b0;
            vprev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            k_q     <= k_d;
            z_q     <= z_d;
            flip_q  <= flip_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            err_q   <= err_d;
            vprev_q <= bus.cordic_valid;
        end
    end

    logic core_busy;
    assign core_busy             = rst && (state_q == S_LAUNCH || state_q == S_WAIT);
    assign bus.in_ready          = rst && state_q == S_IDLE;
    assign bus.cordic_enable     = rst && state_q == S_LAUNCH;
    assign bus.cordic_mode_op    = 1'b0;
    assign bus.cordic_mode_coord = 2'b01;
    assign bus.cordic_x_in       = core_busy ? K_GAIN : '0;
    assign bus.cordic_y_in       = '0;
    assign bus.cordic_z_in       = core_busy ? z_q : '0;
    assign bus.out_valid         = rst && state_q == S_OUT;
    assign bus.sin_out           = rst ? sin_q : '0;
    assign bus.cos_out           = rst ? cos_q : '0;
    assign bus.err               = rst && err_q;
endmodule

// File: doc/cordic_sincos_seq.md
# cordic_sincos_seq

Sequencer that sits directly upstream of the `cordic` core and drives it in CIRCULAR/ROTATION mode to compute sine and cosine of an arbitrary Q16.16 angle in radians. It range-reduces the angle into the core's convergence range [-π/2, π/2], launches the core, and captures its result. It then applies the quadrant sign correction and presents sin/cos on a valid/ready output. The input side is also valid/ready.

## Interface
- `WIDTH`, 32, data width; Q16.16 only, so only 32 is supported.
- `TIMEOUT`, 64, watchdog limit in cycles for the core's `valid`. Used only with the watchdog macro.
- `clk`  input  1  clock
- `rst`  input  1  synchronous, active-low reset (0 = reset)
- `in_valid`  input  1  angle request
- `in_ready`  output  1  sequencer can accept an angle
- `angle_in`  input  32  signed Q16.16 radians, full range
- `cordic_enable`  output  1  one-cycle launch pulse to the core
- `cordic_mode_op`  output  1  constant 0 (ROTATION)
- `cordic_mode_coord`  output  2  constant 2'b01 (CIRCULAR)
- `cordic_x_in`, `cordic_y_in`, `cordic_z_in`  output  32  core operands
- `cordic_x_out`, `cordic_y_out`  input  32  core results
- `cordic_valid`  input  1  core result valid
- `out_valid`  output  1  result available
- `out_ready`  input  1  consumer accepts result
- `sin_out`, `cos_out`  output  32  signed Q16.16
- `err`  output  1  result is a watchdog timeout, not a valid result

## Operation
- FSM states: IDLE → REDUCE → FOLD → LAUNCH → WAIT → OUT → IDLE.
- Constants (Q16.16):
  - 2π = 411775
  - π = 205887
  - π/2 = 102944
  - CORDIC gain compensation K = 39797
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`, register `neg = angle_in[31]` and `a = |angle_in|`.
  - 0x80000000 saturates to 0x7FFFFFFF.
  - `a` is held in a 33-bit unsigned register.
- REDUCE: 14 cycles, k = 13 down to 0. Each cycle: if `a ≥ (2π<<k)`, then `a -= 2π<<k`. The shifted constants are 33 bits. Result: a ∈ [0, 2π).
- FOLD: one cycle, combinational chain, registered.
  1. If `neg` and a ≠ 0: a = 2π − a.
  2. If a > π: a −= 2π, giving a ∈ (−π, π].
  3. If a > π/2: z = a − π and `flip` = 1.
  4. Else if a < −π/2: z = a + π and `flip` = 1.
  5. Else z = a and `flip` = 0.
- LAUNCH: one cycle.
  - `cordic_enable` = 1.
  - `cordic_x_in` = 39797, `cordic_y_in` = 0, `cordic_z_in` = z.
  - Operands are held stable from LAUNCH until the end of WAIT.
- WAIT:
  - Detect the rising edge of `cordic_valid` against its registered previous value, so a level left high from a prior job is ignored.
  - On the edge: `sin_out` = flip ? −y : y and `cos_out` = flip ? −x : x, both registered.
  - Negating −2^31 saturates to 2^31−1.
- OUT:
  - `out_valid` = 1; `sin_out`/`cos_out`/`err` are held stable.
  - On `out_ready`, go to IDLE.
- Boundary conditions:
  - `angle_in` = 0: sin = core y, cos = core x, `flip` = 0.
  - Exactly π/2 is not flipped. Exactly π is flipped, giving z = 0.
  - `in_valid` outside IDLE is ignored; `in_ready` = 0.

## Timing
- Reset (`rst` = 0 at a clock edge):
  - State goes to IDLE.
  - All outputs read 0 while `rst` = 0, including `in_ready`; the constant mode outputs keep their constant values.
  - This is a mid-operation abort: the pending job is dropped, and any later core `valid` is ignored via the edge detector reset.
- Accept cycle is cycle 0.
- REDUCE occupies cycles 1–14, FOLD cycle 15, and LAUNCH cycle 16.
- `out_valid` rises one cycle after the `cordic_valid` rising edge.
- Total latency is 17 + core latency + 1 cycles.
- Throughput is one job at a time. `in_ready` returns the cycle after the `out_ready` handshake.

## Configuration
- `CORDIC_SEQ_WATCHDOG_EN` defined:
  - WAIT counts cycles.
  - If `TIMEOUT` cycles pass with no `cordic_valid` edge, go to OUT with `err` = 1 and `sin_out` = `cos_out` = 0.
  - `err` clears on the next accept.
- Not defined: WAIT waits indefinitely, and `err` is tied to 0.

## Test plan
- 30° (`angle_in` = 34315) → `sin_out` = 32768 ±64 and `cos_out` = 56756 ±64; `out_valid` rises 1 cycle after the core `valid` edge.
- 150° (171573) → sin +32768 ±64, cos −56756 ±64; the `flip` path is exercised and `cordic_z_in` ≈ −34315.
- −200.0 rad (−13107200) → sin 57233 ±64, cos 31934 ±64. Also 0x80000000 → completes without hang.
- Backpressure:
  - Hold `out_ready` = 0 for 20 cycles; outputs stay stable and `in_ready` = 0.
  - Then assert `out_ready` with `in_valid` pending; the next job is accepted the cycle after the handshake.
- Reset mid-operation:
  - Drop `rst` during REDUCE; next cycle `out_valid` = 0 and `in_ready` = 0.
  - Release `rst`; `in_ready` = 1, and a late core `valid` produces no output.
- With `CORDIC_SEQ_WATCHDOG_EN`, `TIMEOUT` = 64, and the core `valid` held low → `out_valid` with `err` = 1 and outputs 0 after 64 WAIT cycles. The next job clears `err`.
